// File: rtl/uart_rx_fifo_ctrl_if.sv
// uart_rx_fifo_ctrl_if: host-side valid/ready byte stream
interface uart_rx_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: pushes received bytes into the RX FIFO, drains it to the host stream, raises interrupts
module uart_rx_fifo_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 32,
    parameter int LVL_WIDTH   = $clog2(DEPTH) + 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    uart_rx_fifo_ctrl_if.master   m,
    input  logic [LVL_WIDTH-1:0]  rx_thresh,
    input  logic                  clr_overrun,
    output logic [LVL_WIDTH-1:0]  level,
    output logic                  overrun,
    output logic                  timeout,
    output logic                  irq
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, HOLD} state_t;

    state_t                state_q, state_d;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] wr_data_q, m_data_q;
    logic [LVL_WIDTH-1:0]  level_q, level_d;
    logic [CW-1:0]         idle_q, idle_d;
    logic                  overrun_q, overrun_d, timeout_q, timeout_d, irq_q, irq_d;
    logic                  full, wr_go, drop, rd_go;

    // Fullness is judged on the registered level: a read in the same cycle cannot make room.
    assign full  = level_q == LVL_WIDTH'(DEPTH);
    assign wr_go = rx_valid && !full;
    assign drop  = rx_valid && full;
    assign rd_go = state_q == FETCH;

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign fifo_rd_en   = rd_go;
    assign m.valid      = state_q == HOLD;
    assign m.data       = m_data_q;
    assign level        = level_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;
    assign irq          = irq_q;

    // Read sequencer: fetch one byte, wait out the FIFO read latency, hold it until the host takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (level_q != '0) ? FETCH : IDLE;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD:    state_d = m.ready ? ((level_q != '0) ? FETCH : IDLE) : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // Occupancy, sticky overrun, idle timer; irq built from next-state values so it tracks them without lag.
    always_comb begin
        level_d   = level_q + LVL_WIDTH'(wr_go) - LVL_WIDTH'(rd_go);
        overrun_d = drop || (overrun_q && !clr_overrun);
        idle_d    = (rx_valid || level_q == '0) ? '0 :
                    (idle_q == CW'(TIMEOUT_CYC)) ? idle_q : idle_q + CW'(1);
        timeout_d = idle_d == CW'(TIMEOUT_CYC) && level_d != '0;
        irq_d     = (rx_thresh != '0 && level_d >= rx_thresh) || timeout_d || overrun_d;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            m_data_q  <= '0;
            level_q   <= '0;
            idle_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_go;
            if (wr_go) wr_data_q <= rx_data;
            if (state_q == CAPTURE) m_data_q <= fifo_rd_data;
            level_q   <= level_d;
            idle_q    <= idle_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            irq_q     <= irq_d;
        end
    end
endmodule
